// File: rtl/iob_mem_responder.sv
// rtl/iob_mem_responder.sv - IOB memory responder with configurable response latency
//
// Word-addressed memory behind a single-outstanding IOB request/response port.
// A request is accepted in IDLE, optionally held in WAIT for LATENCY cycles,
// and answered with a one-cycle registered ready strobe in RESP.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   iob_valid_i  request present (held until the initiator samples ready)
//   iob_addr_i   byte address of the request
//   iob_wdata_i  write data
//   iob_wstrb_i  byte write enables, all-zero means read
//   iob_ready_o  one-cycle response strobe
//   iob_rdata_o  read data, valid while iob_ready_o is high, zero otherwise
//   err_o        sticky out-of-range access flag, cleared only by reset

module iob_mem_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LATENCY   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  // Range bounds carry one extra bit so BASE_ADDR + span cannot wrap.
  localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] SPAN      = (ADDR_W+1)'(DEPTH * STRB_W);
  localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + SPAN;

  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              req_hit;

  logic [DATA_W-1:0] mem [DEPTH];

  // Decode of the live request; only meaningful while in IDLE.
  logic [ADDR_W:0]   addr_ext;
  logic              in_hit;
  logic [IDX_W-1:0]  in_idx;

  assign addr_ext = {1'b0, iob_addr_i};
  assign in_hit   = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
  assign in_idx   = IDX_W'((iob_addr_i - BASE_ADDR) >> OFF_W);

  logic              accept;
  logic              commit;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [STRB_W-1:0] cur_wstrb;
  logic              cur_hit;
  logic              cur_read;
  logic [DATA_W-1:0] resp_data;

  assign accept = (state == S_IDLE) && iob_valid_i;

  // Commit happens on the edge that enters RESP: directly from IDLE when
  // there is no latency, otherwise when the WAIT counter has run out.
  assign commit = (ZERO_LAT && accept) || ((state == S_WAIT) && (cnt == 4'd0));

  // With zero latency the commit edge is the accepting edge, so the live
  // inputs are used; otherwise the latched copy is used and inputs seen
  // during WAIT have no effect.
  always_comb begin
    cur_idx   = req_idx;
    cur_wdata = req_wdata;
    cur_wstrb = req_wstrb;
    cur_hit   = req_hit;
    if (state == S_IDLE) begin
      cur_idx   = in_idx;
      cur_wdata = iob_wdata_i;
      cur_wstrb = iob_wstrb_i;
      cur_hit   = in_hit;
    end
  end

  assign cur_read  = (cur_wstrb == '0);
  assign resp_data = (cur_read && cur_hit) ? mem[cur_idx] : '0;

  // Memory is never reset; gating on reset guarantees an abandoned request
  // cannot write even if reset and a clock edge coincide.
  always_ff @(posedge clk) begin
    if (commit && cur_hit && !reset) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (cur_wstrb[i]) begin
          mem[cur_idx][i*8 +: 8] <= cur_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      req_idx     <= '0;
      req_wdata   <= '0;
      req_wstrb   <= '0;
      req_hit     <= 1'b0;
      iob_ready_o <= 1'b0;
      iob_rdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_idx   <= in_idx;
            req_wdata <= iob_wdata_i;
            req_wstrb <= iob_wstrb_i;
            req_hit   <= in_hit;
            if (ZERO_LAT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= LAT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Valid is deliberately not sampled here: the initiator is still
          // dropping it for the request being answered.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (commit) begin
        iob_ready_o <= 1'b1;
        iob_rdata_o <= resp_data;
        if (!cur_hit) begin
          err_o <= 1'b1;
        end
      end else begin
        iob_ready_o <= 1'b0;
        iob_rdata_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iob_mem_responder.sv
// tb/tb_iob_mem_responder.sv - directed self-checking bench for iob_mem_responder
//
// Three instances share clk/reset: index 0 LATENCY=1, index 1 LATENCY=0,
// index 2 LATENCY=3. All use default widths, depth and base address.

module tb_iob_mem_responder;

  logic        clk;
  logic        reset;
  logic        v   [3];
  logic [31:0] a   [3];
  logic [31:0] wd  [3];
  logic [3:0]  ws  [3];
  logic        r   [3];
  logic [31:0] rd  [3];
  logic        e   [3];

  int checks;
  int failures;

  iob_mem_responder #(.LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .iob_valid_i(v[0]), .iob_addr_i(a[0]),
    .iob_wdata_i(wd[0]), .iob_wstrb_i(ws[0]), .iob_ready_o(r[0]),
    .iob_rdata_o(rd[0]), .err_o(e[0])
  );

  iob_mem_responder #(.LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .iob_valid_i(v[1]), .iob_addr_i(a[1]),
    .iob_wdata_i(wd[1]), .iob_wstrb_i(ws[1]), .iob_ready_o(r[1]),
    .iob_rdata_o(rd[1]), .err_o(e[1])
  );

  iob_mem_responder #(.LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .iob_valid_i(v[2]), .iob_addr_i(a[2]),
    .iob_wdata_i(wd[2]), .iob_wstrb_i(ws[2]), .iob_ready_o(r[2]),
    .iob_rdata_o(rd[2]), .err_o(e[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request starting #1 after a rising edge with the DUT idle.
  // n is the number of edges until ready is seen (first edge = acceptance),
  // 0 on timeout. Afterwards the RESP-exit edge is consumed and the pulse
  // is checked to have ended with rdata back at zero.
  task automatic do_access(input int k, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           output int n, output logic [31:0] data);
    v[k] = 1'b1; a[k] = addr; wd[k] = wdata; ws[k] = wstrb;
    n = 0; data = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (r[k]) begin
        n = i; data = rd[k];
        break;
      end
    end
    v[k] = 1'b0; ws[k] = 4'h0; wd[k] = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (r[k] !== 1'b0 || rd[k] !== 32'h0) begin
      failures++;
      $display("FAIL pulse_end[%0d]: ready=%0b rdata=%08h expected ready=0 rdata=00000000", k, r[k], rd[k]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; a[k] = 32'h0; wd[k] = 32'h0; ws[k] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (r[k] !== 1'b0) begin
        failures++; $display("FAIL reset_ready[%0d]: got %0b expected 0", k, r[k]);
      end
      checks++;
      if (rd[k] !== 32'h0) begin
        failures++; $display("FAIL reset_rdata[%0d]: got %08h expected 00000000", k, rd[k]);
      end
      checks++;
      if (e[k] !== 1'b0) begin
        failures++; $display("FAIL reset_err[%0d]: got %0b expected 0", k, e[k]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int n; logic [31:0] d;
    do_access(0, 32'h10, 32'hDEADBEEF, 4'b1111, n, d);
    checks++;
    if (n != 2) begin failures++; $display("FAIL wr_latency: got %0d expected 2", n); end
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL wr_rdata: got %08h expected 00000000", d); end
    do_access(0, 32'h10, 32'h0, 4'b0000, n, d);
    checks++;
    if (n != 2) begin failures++; $display("FAIL rd_latency: got %0d expected 2", n); end
    checks++;
    if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %08h expected deadbeef", d); end
    // Byte offset bits are ignored: 0x13 addresses the same word.
    do_access(0, 32'h13, 32'h0, 4'b0000, n, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_unaligned: got %08h expected deadbeef", d); end
  endtask

  task automatic test_partial_write();
    int n; logic [31:0] d;
    do_access(0, 32'h10, 32'h0000AA00, 4'b0010, n, d);
    do_access(0, 32'h10, 32'h0, 4'b0000, n, d);
    checks++;
    if (d !== 32'hDEADAAEF) begin failures++; $display("FAIL partial: got %08h expected deadaaef", d); end
  endtask

  task automatic test_out_of_range();
    int n; logic [31:0] d;
    do_access(0, 32'h0, 32'hCAFEF00D, 4'b1111, n, d);
    checks++;
    if (e[0] !== 1'b0) begin failures++; $display("FAIL oor_err_before: got %0b expected 0", e[0]); end
    do_access(0, 32'h1000, 32'h0, 4'b0000, n, d);
    checks++;
    if (n != 2) begin failures++; $display("FAIL oor_rd_latency: got %0d expected 2", n); end
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL oor_rd_data: got %08h expected 00000000", d); end
    checks++;
    if (e[0] !== 1'b1) begin failures++; $display("FAIL oor_err_set: got %0b expected 1", e[0]); end
    do_access(0, 32'h1000, 32'h12345678, 4'b1111, n, d);
    do_access(0, 32'h0, 32'h0, 4'b0000, n, d);
    checks++;
    if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL oor_mem_unchanged: got %08h expected cafef00d", d); end
    checks++;
    if (e[0] !== 1'b1) begin failures++; $display("FAIL oor_err_sticky: got %0b expected 1", e[0]); end
  endtask

  task automatic test_back_to_back(input int k, input int lat);
    int n; int n1; int n2; logic [31:0] d; logic [31:0] d1; logic [31:0] d2;
    logic seen;
    do_access(k, 32'h40, 32'hA5A50001, 4'b1111, n, d);
    checks++;
    if (n != lat + 1) begin failures++; $display("FAIL b2b_wr_latency[%0d]: got %0d expected %0d", k, n, lat + 1); end
    do_access(k, 32'h44, 32'h5A5A0002, 4'b1111, n, d);
    // First read; valid stays high and is retargeted as soon as ready is seen.
    v[k] = 1'b1; a[k] = 32'h40; ws[k] = 4'h0;
    n1 = 0; d1 = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (r[k]) begin n1 = i; d1 = rd[k]; break; end
    end
    a[k] = 32'h44;
    // The next edge leaves RESP without sampling valid; the one after accepts.
    n2 = 0; d2 = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (r[k]) begin n2 = i; d2 = rd[k]; break; end
    end
    v[k] = 1'b0;
    checks++;
    if (n1 != lat + 1) begin failures++; $display("FAIL b2b_first_latency[%0d]: got %0d expected %0d", k, n1, lat + 1); end
    checks++;
    if (d1 !== 32'hA5A50001) begin failures++; $display("FAIL b2b_first_data[%0d]: got %08h expected a5a50001", k, d1); end
    checks++;
    if (n2 != lat + 2) begin failures++; $display("FAIL b2b_second_latency[%0d]: got %0d expected %0d", k, n2, lat + 2); end
    checks++;
    if (d2 !== 32'h5A5A0002) begin failures++; $display("FAIL b2b_second_data[%0d]: got %08h expected 5a5a0002", k, d2); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (r[k]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL b2b_extra_response[%0d]: got 1 expected 0", k); end
  endtask

  task automatic test_reset_in_wait();
    int n; logic [31:0] d; logic seen;
    do_access(2, 32'h20, 32'h11223344, 4'b1111, n, d);
    checks++;
    if (n != 4) begin failures++; $display("FAIL riw_setup_latency: got %0d expected 4", n); end
    v[2] = 1'b1; a[2] = 32'h20; wd[2] = 32'hFFFFFFFF; ws[2] = 4'b1111;
    @(posedge clk); #1;
    v[2] = 1'b0; ws[2] = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (e[0] !== 1'b0) begin failures++; $display("FAIL riw_err_cleared: got %0b expected 0", e[0]); end
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (r[2]) seen = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (r[2]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL riw_ready_pulsed: got 1 expected 0"); end
    do_access(2, 32'h20, 32'h0, 4'b0000, n, d);
    checks++;
    if (d !== 32'h11223344) begin failures++; $display("FAIL riw_mem_kept: got %08h expected 11223344", d); end
    checks++;
    if (e[2] !== 1'b0) begin failures++; $display("FAIL riw_err: got %0b expected 0", e[2]); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_back_to_back(1, 0);
    test_back_to_back(2, 3);
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_mem_responder.md
IOB_MEM_RESPONDER -- requirements
Module: iob_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 32, IOB address width.
REQ-002 Parameter DATA_W, default 32, IOB data width (multiple of 8).
REQ-003 Parameter DEPTH, default 1024, number of DATA_W words stored (power of 2).
REQ-004 Parameter BASE_ADDR, default 0, byte address of word 0 (DEPTH*DATA_W/8 aligned).
REQ-005 Parameter LATENCY, default 1, range 0..15, extra wait cycles before response.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 iob_valid_i  input  1  request present; held high by the initiator until it samples ready.
REQ-009 iob_addr_i  input  ADDR_W  byte address of the request.
REQ-010 iob_wdata_i  input  DATA_W  write data.
REQ-011 iob_wstrb_i  input  DATA_W/8  byte write enables; all-zero means read.
REQ-012 iob_ready_o  output  1  one-cycle response strobe, registered.
REQ-013 iob_rdata_o  output  DATA_W  read data, valid while iob_ready_o=1, registered.
REQ-014 err_o  output  1  sticky out-of-range access flag.

Function
REQ-015 The block SHALL implement states IDLE, WAIT and RESP.
REQ-016 In IDLE, iob_valid_i=1 at a rising edge SHALL accept the request: latch addr, wdata and wstrb, compute the word index (addr-BASE_ADDR)>>log2(DATA_W/8), and ignore the low byte-offset bits.
REQ-017 In-range SHALL mean BASE_ADDR <= addr < BASE_ADDR+DEPTH*DATA_W/8.
REQ-018 With LATENCY=0, acceptance SHALL go directly to RESP, with ready and rdata registered at the accepting edge.
REQ-019 With LATENCY>0, acceptance SHALL load a counter with LATENCY-1 and enter WAIT. WAIT SHALL decrement the counter each cycle and transition to RESP at the edge where it equals 0.
REQ-020 ready SHALL therefore be high exactly in cycle E0+1+LATENCY, where E0 is the accepting edge.
REQ-021 Write commit: on the edge entering RESP, each byte lane i with wstrb[i]=1 SHALL be written to mem[index]; other lanes are unchanged.
REQ-022 Writes SHALL return rdata=0.
REQ-023 Read: on the edge entering RESP, rdata SHALL load mem[index].
REQ-024 Out-of-range: the block SHALL still respond with the same latency, ignore the write, return rdata=0, and set err_o=1 on the edge entering RESP.
REQ-025 RESP SHALL last exactly one cycle and then return to IDLE unconditionally. iob_valid_i is not sampled in RESP, because the initiator drops valid on that same edge.
REQ-026 iob_ready_o SHALL be 0 in IDLE and WAIT. iob_rdata_o SHALL return to 0 when leaving RESP.
REQ-027 Input changes during WAIT SHALL be ignored; the latched request is used.
REQ-028 Back-to-back: valid high in the first IDLE cycle after RESP SHALL be accepted at that edge, with no further idle cycles required.
REQ-029 iob_valid_i=0 in IDLE SHALL keep the block in IDLE with no memory access.
REQ-030 err_o SHALL clear only on reset.

Reset
REQ-031 reset SHALL immediately force state=IDLE, counter=0, iob_ready_o=0, iob_rdata_o=0 and err_o=0.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 A request in WAIT when reset asserts SHALL be abandoned with no memory write. After reset releases, the block SHALL wait for a fresh valid.

Verification
REQ-034 LATENCY=1, write addr 0x10, wdata 0xDEADBEEF, wstrb 4'b1111, then read 0x10 -> ready high 2 cycles after acceptance for each access; the read returns 0xDEADBEEF.
REQ-035 Partial write wstrb 4'b0010, wdata 0x0000AA00 to 0x10, then read -> 0xDEADAAEF.
REQ-036 LATENCY=0 and LATENCY=3, back-to-back reads with valid held until ready -> ready pulses exactly one cycle, at E0+1 and E0+4 respectively; one response per request.
REQ-037 Read of BASE_ADDR+4*DEPTH (0x1000 at defaults) -> ready after latency, rdata=0, err_o=1 and stays 1; memory unchanged.
REQ-038 Assert reset during WAIT of a write to 0x20 (LATENCY=3) -> ready never pulses; a later read of 0x20 returns its pre-write value; err_o=0.
